lockstep_divergence_monitor: RTL
================================

# lockstep_divergence_monitor

Parametrised run controller and divergence checker for N-copy lockstep harnesses around the Sodor core.
- Sequences core reset and the initial-state window, and tells the harness when to constrain architectural state equal.
- Compares each copy's load-buffer table port (valid/addr/optional data) against copy 0 every cycle.
- Latches the first divergence (cycle and copy mask) and produces a single pass/fail verdict at a configurable check cycle.
- Supports point or cumulative checking, and replaces hand-coded per-harness counters in the BMC top levels.

## Interface
Parameters:
- NCOPY, 2: number of core copies compared (2..8).
- AW, 32: lb table address width.
- DW, 32: lb table data width.
- CNT_W, 5: cycle counter width.
- RESET_CYCLES, 2: cycles core_reset is held after monitor reset release.
- INIT_CYCLES, 8: cycles init_window stays high; must satisfy RESET_CYCLES <= INIT_CYCLES.
- CHECK_CYCLE, 18: cycle at which the verdict is taken; INIT_CYCLES <= CHECK_CYCLE < 2^CNT_W-1.
- CHECK_MODE, 0: 0 = point check (divergence present at CHECK_CYCLE only); 1 = cumulative (any divergence from RESET_CYCLES through CHECK_CYCLE).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high monitor reset.
- lb_valid, in, NCOPY: per-copy lb table valid, copy i at bit i.
- lb_addr, in, NCOPY*AW: per-copy lb address, copy i at [i*AW +: AW].
- lb_data, in, NCOPY*DW: per-copy lb data, same packing as lb_addr.
- cmp_data_en, in, 1: include data in the comparison.
- core_reset, out, 1: reset to all core copies.
- init_window, out, 1: harness initialisation phase.
- equiv_strobe, out, 1: one-cycle pulse; harness assumes architectural state equal this cycle.
- diverge, out, 1: combinational current-cycle divergence, gated by monitoring-active.
- diverge_mask, out, NCOPY: combinational per-copy mismatch vs copy 0; bit 0 always 0.
- diverge_sticky, out, 1: a divergence has been seen.
- first_div_cyc, out, CNT_W: cycle of the first divergence.
- first_div_mask, out, NCOPY: diverge_mask at the first divergence.
- check_strobe, out, 1: high while cyc == CHECK_CYCLE.
- check_fail, out, 1: registered verdict.
- done, out, 1: verdict taken.

## Operation
- **Cycle counter.** Register cyc, CNT_W bits, resets to 0. Increments on every posedge and saturates at 2^CNT_W-1; it never wraps.
- **Phase decodes** (all from registered cyc):
  - core_reset = cyc < RESET_CYCLES.
  - init_window = cyc < INIT_CYCLES.
  - equiv_strobe = cyc == RESET_CYCLES.
  - check_strobe = cyc == CHECK_CYCLE.
- **Monitoring active** = (cyc >= RESET_CYCLES) & !done.
- **Per-copy mismatch**, for copy i ≥ 1, measured against copy 0. mism_i is true if any of:
  - lb_valid[i] ^ lb_valid[0];
  - both valid and the addresses differ;
  - cmp_data_en, both valid, and the data differ.
  - When both copies are invalid, addr and data are ignored.
- diverge_mask[i] = mism_i & active.
- diverge = |diverge_mask.
- **Capture on posedge** when active & diverge & !diverge_sticky:
  - diverge_sticky <= 1;
  - first_div_cyc <= cyc;
  - first_div_mask <= diverge_mask.
  - Later divergences change nothing.
- **Verdict on posedge** when cyc == CHECK_CYCLE & !done:
  - check_fail <= CHECK_MODE ? (diverge_sticky | diverge) : diverge;
  - done <= 1.
- **After done:** sticky, first_div_* and check_fail are frozen until reset.
- **States** (implicit in cyc/done): RESET_HOLD (cyc < RESET_CYCLES) -> RUN -> CHECKED (done = 1, terminal).

## Timing
- **Reset values:**
  - cyc = 0, done = 0, diverge_sticky = 0, check_fail = 0, first_div_cyc = 0, first_div_mask = 0.
  - Hence core_reset = 1 and init_window = 1 during reset.
  - equiv_strobe = 1 only if RESET_CYCLES == 0; check_strobe = 1 only if CHECK_CYCLE == 0.
- **Reset assertion mid-run:** all registers clear immediately (asynchronous) and the sequence restarts from cyc = 0.
- **Post-release sequencing:** with the defaults, core_reset is high for exactly 2 cycles after release, equiv_strobe pulses at cyc 2, and init_window falls at cyc 8.
- **Divergence latency:**
  - diverge is zero-latency.
  - sticky and first_* are visible the cycle after the divergent cycle.
  - A divergence at cyc == CHECK_CYCLE is captured and also counted in the verdict.
- **Verdict latency:** check_fail and done are visible at cyc = CHECK_CYCLE+1 and stay until reset.
- **Inputs ignored:** no capture while core_reset is high or after done.

## Test plan
- **Identical streams:** all copies driven identically, valid pulsing with addr 0x64, NCOPY=2 -> diverge never 1; at cyc 19 done=1, check_fail=0, diverge_sticky=0.
- **Valid mismatch:** lb_valid = 2'b01 at cyc 10 only -> diverge=1 at cyc 10; from cyc 11 diverge_sticky=1, first_div_cyc=10, first_div_mask=2'b10.
- **Mode difference:** same transient as the valid-mismatch test, equal at cyc 18 -> CHECK_MODE=0 gives check_fail=0; CHECK_MODE=1 gives check_fail=1.
- **Data compare gating:** both valid, addr equal, data 0x1 vs 0x2 at cyc 5 -> cmp_data_en=0 gives no divergence; cmp_data_en=1 gives first_div_cyc=5.
- **Three copies:** NCOPY=3, copy 2 addr 0x68 vs 0x64 at cyc 7, copy 1 differs at cyc 9 -> first_div_mask=3'b100, first_div_cyc=7, unchanged after cyc 9.
- **Pre-monitoring divergence and reset:**
  - Mismatch at cyc 1 (core_reset high) -> ignored, diverge=0.
  - Reset asserted at cyc 12 after a divergence -> all outputs return to reset values immediately, and the sequence reruns cleanly.

Source files
------------

// File: rtl/lockstep_divergence_monitor.sv
// Run controller and divergence checker for N-copy lockstep harnesses.
// Sequences core reset / init window, compares lb ports vs copy 0, latches first divergence, gives a verdict.
module lockstep_divergence_monitor #(
    parameter int NCOPY        = 2,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int CNT_W        = 5,
    parameter int RESET_CYCLES = 2,
    parameter int INIT_CYCLES  = 8,
    parameter int CHECK_CYCLE  = 18,
    parameter int CHECK_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCOPY-1:0]      lb_valid,
    input  logic [NCOPY*AW-1:0]   lb_addr,
    input  logic [NCOPY*DW-1:0]   lb_data,
    input  logic                  cmp_data_en,
    output logic                  core_reset,
    output logic                  init_window,
    output logic                  equiv_strobe,
    output logic                  diverge,
    output logic [NCOPY-1:0]      diverge_mask,
    output logic                  diverge_sticky,
    output logic [CNT_W-1:0]      first_div_cyc,
    output logic [NCOPY-1:0]      first_div_mask,
    output logic                  check_strobe,
    output logic                  check_fail,
    output logic                  done
);

    // state      | meaning
    // RESET_HOLD | cyc < RESET_CYCLES: cores held in reset, inputs ignored
    // RUN        | monitoring active, first divergence captured
    // CHECKED    | done = 1: verdict and capture frozen until reset

    localparam logic [CNT_W-1:0] CYC_MAX   = '1;
    localparam logic [CNT_W-1:0] RST_END   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] INIT_END  = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] CHECK_CYC = CNT_W'(CHECK_CYCLE);

    logic [CNT_W-1:0] cyc;
    logic [NCOPY-1:0] mism;
    logic             active;

    assign core_reset   = (cyc < RST_END);
    assign init_window  = (cyc < INIT_END);
    assign equiv_strobe = (cyc == RST_END);
    assign check_strobe = (cyc == CHECK_CYC);
    assign active       = !core_reset && !done;

    // Addr/data only matter when both copies hold a valid entry.
    always_comb begin
        mism = '0;
        for (int i = 1; i < NCOPY; i++) begin
            mism[i] = (lb_valid[i] ^ lb_valid[0])
                    | (lb_valid[i] & lb_valid[0]
                       & ((lb_addr[i*AW +: AW] != lb_addr[AW-1:0])
                          | (cmp_data_en & (lb_data[i*DW +: DW] != lb_data[DW-1:0]))));
        end
    end

    assign diverge_mask = mism & {NCOPY{active}};
    assign diverge      = |diverge_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc            <= '0;
            done           <= 1'b0;
            diverge_sticky <= 1'b0;
            check_fail     <= 1'b0;
            first_div_cyc  <= '0;
            first_div_mask <= '0;
        end else begin
            if (cyc != CYC_MAX)
                cyc <= cyc + 1'b1;
            if (active && diverge && !diverge_sticky) begin
                diverge_sticky <= 1'b1;
                first_div_cyc  <= cyc;
                first_div_mask <= diverge_mask;
            end
            // A divergence in the check cycle itself still counts in either mode.
            if (check_strobe && !done) begin
                check_fail <= (CHECK_MODE != 0) ? (diverge_sticky | diverge) : diverge;
                done       <= 1'b1;
            end
        end
    end

endmodule
